naive_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one naive_bus slave (instruction ROM, RAM, or a peripheral) between `N_MASTER` naive_bus masters such as the instruction-fetch and data ports. It selects one requesting master per handshake and forwards that master's read/write request to the slave. It returns the slave's grant combinationally and steers the registered read data back to the owning master one cycle later. It sits between the core's bus ports and each shared slave.

---
 rtl/naive_bus_arbiter_if.sv | 23 ++
 rtl/naive_bus_arbiter.sv | 110 +++++++++++
 tb/tb_naive_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/naive_bus_arbiter_if.sv
// naive_bus point-to-point link: read/write request channels with a combinational grant
// and a read-data return one cycle after the read grant.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/naive_bus_arbiter.sv
// Round-robin arbiter sharing one naive_bus slave between N_MASTER masters; the winner is
// held across a stalled handshake and read data is steered back by the registered owner.
module naive_bus_arbiter #(
  parameter int unsigned N_MASTER = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  naive_bus.slave  mst [N_MASTER],
  naive_bus.master slv
);

  localparam int unsigned IdxW = $clog2(N_MASTER);
  typedef logic [IdxW-1:0] idx_t;

  logic [N_MASTER-1:0] m_rd_req;
  logic [N_MASTER-1:0] m_wr_req;
  logic [N_MASTER-1:0] m_req;
  logic [31:0]         m_rd_addr [N_MASTER];
  logic [31:0]         m_wr_addr [N_MASTER];
  logic [31:0]         m_wr_data [N_MASTER];
  logic [3:0]          m_wr_be   [N_MASTER];

  idx_t rr_ptr_q, lock_idx_q, rd_own_q;
  logic lock_q, rd_own_v_q;

  idx_t        winner;
  logic        winner_v;
  logic        done;
  logic        fwd_rd_req, fwd_wr_req;
  logic [31:0] fwd_rd_addr, fwd_wr_addr, fwd_wr_data;
  logic [3:0]  fwd_wr_be;

  for (genvar g = 0; g < N_MASTER; g++) begin : g_mst
    assign m_rd_req[g]  = mst[g].rd_req;
    assign m_wr_req[g]  = mst[g].wr_req;
    assign m_req[g]     = mst[g].rd_req | mst[g].wr_req;
    assign m_rd_addr[g] = mst[g].rd_addr;
    assign m_wr_addr[g] = mst[g].wr_addr;
    assign m_wr_data[g] = mst[g].wr_data;
    assign m_wr_be[g]   = mst[g].wr_be;

    assign mst[g].rd_gnt  = winner_v && (winner == idx_t'(g)) && slv.rd_gnt;
    assign mst[g].wr_gnt  = winner_v && (winner == idx_t'(g)) && slv.wr_gnt;
    assign mst[g].rd_data = (rd_own_v_q && (rd_own_q == idx_t'(g))) ? slv.rd_data : '0;
  end

  // A held lock pins the winner; a lock-holder that drops its request yields no winner.
  always_comb begin
    int unsigned idx;
    winner   = '0;
    winner_v = 1'b0;
    idx      = 0;
    if (lock_q) begin
      winner   = lock_idx_q;
      winner_v = m_req[lock_idx_q];
    end else begin
      for (int unsigned k = 0; k < N_MASTER; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= N_MASTER) idx = idx - N_MASTER;
        if (!winner_v && m_req[idx]) begin
          winner   = idx_t'(idx);
          winner_v = 1'b1;
        end
      end
    end
  end

  always_comb begin
    fwd_rd_req  = 1'b0;
    fwd_wr_req  = 1'b0;
    fwd_rd_addr = '0;
    fwd_wr_addr = '0;
    fwd_wr_data = '0;
    fwd_wr_be   = '0;
    if (winner_v) begin
      fwd_rd_req  = m_rd_req[winner];
      fwd_wr_req  = m_wr_req[winner];
      fwd_rd_addr = m_rd_addr[winner];
      fwd_wr_addr = m_wr_addr[winner];
      fwd_wr_data = m_wr_data[winner];
      fwd_wr_be   = m_wr_be[winner];
    end
  end

  assign slv.rd_req  = fwd_rd_req;
  assign slv.wr_req  = fwd_wr_req;
  assign slv.rd_addr = fwd_rd_addr;
  assign slv.wr_addr = fwd_wr_addr;
  assign slv.wr_data = fwd_wr_data;
  assign slv.wr_be   = fwd_wr_be;

  assign done = winner_v && (!fwd_rd_req || slv.rd_gnt) && (!fwd_wr_req || slv.wr_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rd_own_v_q <= 1'b0;
      rd_own_q   <= '0;
    end else begin
      lock_q <= winner_v && !done;
      if (winner_v && !done) lock_idx_q <= winner;
      if (done) rr_ptr_q <= (winner == idx_t'(N_MASTER - 1)) ? '0 : winner + 1'b1;
      rd_own_v_q <= slv.rd_gnt && fwd_rd_req;
      rd_own_q   <= winner;
    end
  end

endmodule

// File: tb/tb_naive_bus_arbiter.sv
// Randomized bench for naive_bus_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level arbitration model.
module tb_naive_bus_arbiter;

  localparam int N = 2;

  logic clk;
  logic rst_n;

  naive_bus mst_if [N] ();
  naive_bus slv_if ();

  logic        m_rd_req [N];
  logic        m_wr_req [N];
  logic [31:0] m_rd_addr [N];
  logic [31:0] m_wr_addr [N];
  logic [31:0] m_wr_data [N];
  logic [3:0]  m_wr_be [N];
  logic        m_rd_gnt [N];
  logic        m_wr_gnt [N];
  logic [31:0] m_rd_data [N];

  logic        s_rd_gnt, s_wr_gnt;
  logic [31:0] s_rd_data;

  for (genvar g = 0; g < N; g++) begin : g_m
    assign mst_if[g].rd_req  = m_rd_req[g];
    assign mst_if[g].wr_req  = m_wr_req[g];
    assign mst_if[g].rd_addr = m_rd_addr[g];
    assign mst_if[g].wr_addr = m_wr_addr[g];
    assign mst_if[g].wr_data = m_wr_data[g];
    assign mst_if[g].wr_be   = m_wr_be[g];
    assign m_rd_gnt[g]  = mst_if[g].rd_gnt;
    assign m_wr_gnt[g]  = mst_if[g].wr_gnt;
    assign m_rd_data[g] = mst_if[g].rd_data;
  end

  assign slv_if.rd_gnt  = s_rd_gnt;
  assign slv_if.wr_gnt  = s_wr_gnt;
  assign slv_if.rd_data = s_rd_data;

  naive_bus_arbiter #(.N_MASTER(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mst   (mst_if),
    .slv   (slv_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: next master to search from, locked owner (-1 = none), pending return.
  int          rr;
  int          lk;
  bit          ret_v;
  int          ret_own;
  logic [31:0] ret_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] addr);
    if (addr == 32'h14) return 32'h008000ef;
    return (addr * 32'h9E3779B1) ^ 32'h1234;
  endfunction

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      m_rd_req[i] = 1'b0;
      m_wr_req[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    rr    = 0;
    lk    = -1;
    ret_v = 1'b0;
  endtask

  // Called just after a rising edge with inputs set; checks this cycle and advances the model.
  task automatic step();
    int w, wi;
    bit done;
    #1;
    w = -1;
    if (lk >= 0) begin
      if (m_rd_req[lk] || m_wr_req[lk]) w = lk;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (rr + k) % N;
        if (w < 0 && (m_rd_req[j] || m_wr_req[j])) w = j;
      end
    end
    wi = (w < 0) ? 0 : w;
    check("slv_rd_req",  slv_if.rd_req,  (w >= 0) ? m_rd_req[wi]  : 1'b0);
    check("slv_wr_req",  slv_if.wr_req,  (w >= 0) ? m_wr_req[wi]  : 1'b0);
    check("slv_rd_addr", slv_if.rd_addr, (w >= 0) ? m_rd_addr[wi] : 32'h0);
    check("slv_wr_addr", slv_if.wr_addr, (w >= 0) ? m_wr_addr[wi] : 32'h0);
    check("slv_wr_data", slv_if.wr_data, (w >= 0) ? m_wr_data[wi] : 32'h0);
    check("slv_wr_be",   slv_if.wr_be,   (w >= 0) ? m_wr_be[wi]   : 4'h0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rd_gnt%0d", i), m_rd_gnt[i], (w == i) ? s_rd_gnt : 1'b0);
      check($sformatf("wr_gnt%0d", i), m_wr_gnt[i], (w == i) ? s_wr_gnt : 1'b0);
      check($sformatf("rd_data%0d", i), m_rd_data[i],
            (ret_v && ret_own == i) ? ret_data : 32'h0);
    end
    done = (w >= 0) && (!m_rd_req[wi] || s_rd_gnt) && (!m_wr_req[wi] || s_wr_gnt);
    ret_v    = (w >= 0) && m_rd_req[wi] && s_rd_gnt;
    ret_own  = wi;
    ret_data = rom(m_rd_addr[wi]);
    if (done) begin
      rr = (w + 1) % N;
      lk = -1;
    end else begin
      lk = w;
    end
    @(posedge clk);
    #1;
    s_rd_data = ret_v ? ret_data : $urandom();
    if (done) begin
      m_rd_req[wi] = 1'b0;
      m_wr_req[wi] = 1'b0;
    end
  endtask

  initial begin
    clear_reqs();
    for (int i = 0; i < N; i++) begin
      m_rd_addr[i] = '0;
      m_wr_addr[i] = '0;
      m_wr_data[i] = '0;
      m_wr_be[i]   = '0;
    end
    // Reset with a noisy slave: nothing may leak to the masters.
    rst_n     = 1'b0;
    s_rd_gnt  = 1'b1;
    s_wr_gnt  = 1'b0;
    s_rd_data = 32'hDEADBEEF;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("rst_rd_data0", m_rd_data[0], 32'h0);
    check("rst_rd_data1", m_rd_data[1], 32'h0);
    check("rst_slv_rd_req", slv_if.rd_req, 1'b0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    s_rd_gnt = 1'b0;
    repeat (2) step();

    // Single master read from ROM.
    s_rd_gnt     = 1'b1;
    m_rd_addr[1] = 32'h14;
    m_rd_req[1]  = 1'b1;
    #1;
    check("single_addr", slv_if.rd_addr, 32'h14);
    step();
    #1;
    check("single_data1", m_rd_data[1], 32'h008000ef);
    check("single_data0", m_rd_data[0], 32'h0);
    step();

    // Contention on an always-granting slave: grants alternate starting at master 0.
    m_rd_addr[0] = 32'h100;
    m_rd_addr[1] = 32'h200;
    for (int k = 0; k < 4; k++) begin
      m_rd_req[0] = 1'b1;
      m_rd_req[1] = 1'b1;
      #1;
      check("alt_gnt0", m_rd_gnt[0], (k % 2) == 0);
      check("alt_gnt1", m_rd_gnt[1], (k % 2) == 1);
      step();
    end
    clear_reqs();
    step();

    // Stall: master 0 keeps the slave for all four cycles while master 1 waits.
    m_rd_req[0] = 1'b1;
    m_rd_req[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_rd_gnt = (k == 3);
      #1;
      check("stall_addr", slv_if.rd_addr, 32'h100);
      step();
    end
    check("stall_next", slv_if.rd_addr, 32'h200);
    step();
    step();

    // Write from master 1.
    s_wr_gnt     = 1'b1;
    m_wr_addr[1] = 32'h00030000;
    m_wr_data[1] = 32'h5;
    m_wr_be[1]   = 4'b0001;
    m_wr_req[1]  = 1'b1;
    #1;
    check("wr_addr", slv_if.wr_addr, 32'h00030000);
    check("wr_data", slv_if.wr_data, 32'h5);
    check("wr_be",   slv_if.wr_be,   4'b0001);
    check("wr_gnt1", m_wr_gnt[1], 1'b1);
    step();
    // rr_ptr wrapped to 0: master 0 wins a fresh contention.
    m_rd_req[0] = 1'b1;
    m_rd_req[1] = 1'b1;
    #1;
    check("wr_rr_gnt0", m_rd_gnt[0], 1'b1);
    step();
    step();
    clear_reqs();
    step();

    // Reset in the cycle after a master 0 read grant.
    m_rd_req[0] = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_data0", m_rd_data[0], 32'h0);
    clear_reqs();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_rd_req[0] = 1'b1;
    m_rd_req[1] = 1'b1;
    #1;
    check("midrst_rr0", m_rd_gnt[0], 1'b1);
    step();
    clear_reqs();
    step();

    // Random traffic; a pending request is held until its handshake completes.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_rd_req[i] && !m_wr_req[i] && ($urandom_range(1) == 1)) begin
          int kind;
          kind = $urandom_range(2);
          m_rd_req[i]  = (kind != 1);
          m_wr_req[i]  = (kind != 0);
          m_rd_addr[i] = $urandom();
          m_wr_addr[i] = $urandom();
          m_wr_data[i] = $urandom();
          m_wr_be[i]   = 4'($urandom());
        end
      end
      s_rd_gnt = ($urandom_range(3) != 0);
      s_wr_gnt = ($urandom_range(3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
